// File: rtl/ber_checker.sv
// Delay-searching BER checker: locks onto the channel delay, then counts bit errors.
// Optional loss-of-lock monitoring is enabled with `define BER_LOSS_OF_LOCK_EN.
module ber_checker #(
    parameter int MAX_DELAY = 16,
    parameter int DW        = 4,
    parameter int WIN       = 64,
    parameter int LOCK_TH   = 0,
    parameter int CNT_W     = 32,
    parameter int LOSS_TH   = 8
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic             i_prbs,
    input  logic             i_sync,
    output logic             o_locked,
    output logic [DW-1:0]    o_delay,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_bit_count
);

    localparam int CW = $clog2(WIN);
    localparam int EW = $clog2(WIN + 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(WIN - 1);
    localparam logic [EW-1:0] LOCK_LIM = EW'(LOCK_TH);
`ifdef BER_LOSS_OF_LOCK_EN
    localparam logic [EW-1:0] LOSS_LIM = EW'(LOSS_TH);
`endif

    typedef enum logic {SEARCH, LOCK} state_t;

    state_t               state;
    logic [MAX_DELAY-1:0] hist;
    logic [CW-1:0]        win_cnt;
    logic [EW-1:0]        win_err;
    logic                 sample;
    logic                 ref_bit;
    logic                 mismatch;
    logic                 win_end;
    logic [EW-1:0]        err_next;

    assign sample   = i_enable & i_valid;
    // hist[0] holds the previous symbol, so delay d maps to hist[d-1]
    assign ref_bit  = (o_delay == '0) ? i_prbs : hist[o_delay - 1'b1];
    assign mismatch = i_sync ^ ref_bit;
    assign err_next = win_err + EW'(mismatch);
    assign win_end  = (win_cnt == WIN_LAST);

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state       <= SEARCH;
            hist        <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            o_locked    <= 1'b0;
            o_delay     <= '0;
            o_err_count <= '0;
            o_bit_count <= '0;
        end else if (sample) begin
            hist <= {hist[MAX_DELAY-2:0], i_prbs};
            unique case (state)
                SEARCH: begin
                    if (win_end) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (err_next <= LOCK_LIM) begin
                            state    <= LOCK;
                            o_locked <= 1'b1;
                        end else begin
                            o_delay <= o_delay + 1'b1;
                        end
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                        win_err <= err_next;
                    end
                end
                LOCK: begin
                    if (o_bit_count != '1)
                        o_bit_count <= o_bit_count + 1'b1;
                    if (mismatch && (o_err_count != '1))
                        o_err_count <= o_err_count + 1'b1;
`ifdef BER_LOSS_OF_LOCK_EN
                    // counters are kept across a loss so the next lock resumes them
                    if (win_end) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (err_next >= LOSS_LIM) begin
                            state    <= SEARCH;
                            o_locked <= 1'b0;
                            o_delay  <= '0;
                        end
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                        win_err <= err_next;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ber_checker.sv
// Randomized scoreboard bench for ber_checker against a queue-based reference model.
module tb_ber_checker;

    localparam int MAXD    = 16;
    localparam int DW      = 4;
    localparam int WIN     = 64;
    localparam int LOCK_TH = 0;
    localparam int CNT_W   = 8;
    localparam int LOSS_TH = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             i_reset = 1'b0;
    logic             i_enable = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_prbs = 1'b0;
    logic             i_sync = 1'b0;
    logic             o_locked;
    logic [DW-1:0]    o_delay;
    logic [CNT_W-1:0] o_err_count;
    logic [CNT_W-1:0] o_bit_count;

    ber_checker #(
        .MAX_DELAY(MAXD), .DW(DW), .WIN(WIN), .LOCK_TH(LOCK_TH),
        .CNT_W(CNT_W), .LOSS_TH(LOSS_TH)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_valid(i_valid), .i_prbs(i_prbs), .i_sync(i_sync),
        .o_locked(o_locked), .o_delay(o_delay),
        .o_err_count(o_err_count), .o_bit_count(o_bit_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit l;
        int d;
        int e;
        int b;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    bit   m_lock;
    int   m_delay, m_wc, m_we, m_err, m_bit;
    bit   m_sent[$];

    // stimulus state
    logic [8:0] lfsr = 9'h1FF;
    int   tx_d = 5;
    bit   inv = 1'b0;
    bit   tx[$];

    task automatic model(input bit rst, input bit en, input bit val,
                         input bit p, input bit s);
        bit r, mm;
        if (rst) begin
            m_lock = 0; m_delay = 0; m_wc = 0; m_we = 0;
            m_err = 0; m_bit = 0;
            m_sent.delete();
        end else if (en && val) begin
            if (m_delay == 0) r = p;
            else if (m_sent.size() >= m_delay) r = m_sent[m_sent.size() - m_delay];
            else r = 1'b0;
            mm = s ^ r;
            if (!m_lock) begin
                m_wc++;
                m_we += int'(mm);
                if (m_wc == WIN) begin
                    if (m_we <= LOCK_TH) m_lock = 1;
                    else m_delay = (m_delay + 1) % MAXD;
                    m_wc = 0; m_we = 0;
                end
            end else begin
                m_bit = (m_bit + 1 > CMAX) ? CMAX : m_bit + 1;
                m_err = (m_err + int'(mm) > CMAX) ? CMAX : m_err + int'(mm);
`ifdef BER_LOSS_OF_LOCK_EN
                m_wc++;
                m_we += int'(mm);
                if (m_wc == WIN) begin
                    if (m_we >= LOSS_TH) begin
                        m_lock = 0; m_delay = 0;
                    end
                    m_wc = 0; m_we = 0;
                end
`endif
            end
            m_sent.push_back(p);
            if (m_sent.size() > MAXD) void'(m_sent.pop_front());
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit val, input bit flip);
        bit p, s, dl, smp;
        exp_t e;
        smp = !rst && en && val;
        if (smp) begin
            p = lfsr[8];
            lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        end else begin
            p = 1'($urandom);
        end
        if (tx_d == 0) dl = p;
        else if (tx.size() >= tx_d) dl = tx[tx.size() - tx_d];
        else dl = 1'b0;
        s = rst ? 1'($urandom) : (dl ^ inv ^ flip);
        if (rst) tx.delete();
        else if (smp) begin
            tx.push_back(p);
            if (tx.size() > 32) void'(tx.pop_front());
        end
        i_reset = rst; i_enable = en; i_valid = val; i_prbs = p; i_sync = s;
        model(rst, en, val, p, s);
        e.l = m_lock; e.d = m_delay; e.e = m_err; e.b = m_bit;
        expq.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) step(0, 1, 0, 0);
            step(0, 1, 1, 0);
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (o_locked !== e.l || int'(o_delay) != e.d ||
                    int'(o_err_count) != e.e || int'(o_bit_count) != e.b) begin
                    errors++;
                    $display("FAIL outs @%0t: got l=%0b d=%0d e=%0d b=%0d, expected l=%0b d=%0d e=%0d b=%0d",
                             $time, o_locked, o_delay, o_err_count, o_bit_count,
                             e.l, e.d, e.e, e.b);
                end
            end
        end
    end

    initial begin : stim
        int pa, pb, pc, bc0, ec0;
        int dl0, bl0, el0;
        bit ll0;
        // 1: reset with random inputs, then reset mid-search
        repeat (3) step(1, 1'($urandom), 1'($urandom), 0);
        chk("rst_locked", int'(o_locked), 0);
        chk("rst_delay", int'(o_delay), 0);
        chk("rst_err", int'(o_err_count), 0);
        chk("rst_bits", int'(o_bit_count), 0);
        inv = 1;
        run(3 * WIN, 1);
        chk("mid_delay3", int'(o_delay), 3);
        step(1, 1, 1, 0);
        chk("mid_rst_delay", int'(o_delay), 0);

        // 2: search for delay 5 with a strobe every 4th clock
        inv = 0; tx_d = 5;
        step(1, 1, 0, 0);
        run(6 * WIN - 1, 4);
        chk("pre_lock", int'(o_locked), 0);
        run(1, 4);
        chk("lock", int'(o_locked), 1);
        chk("lock_delay", int'(o_delay), 5);
        run(50, 4);
        chk("lock_bits", int'(o_bit_count), 50);
        chk("lock_err", int'(o_err_count), 0);

        // 3: inverted reference never locks; delay wraps
        inv = 1;
        step(1, 1, 0, 0);
        run(MAXD * WIN - 1, 1);
        chk("nolock_d15", int'(o_delay), 15);
        run(1, 1);
        chk("nolock_wrap", int'(o_delay), 0);
        chk("nolock_locked", int'(o_locked), 0);

        // 4: three flipped bits over 100 locked samples
        inv = 0;
        step(1, 1, 0, 0);
        run(6 * WIN, 1);
        pa = 10 + $urandom_range(0, 24);
        pb = 40 + $urandom_range(0, 24);
        pc = 75 + $urandom_range(0, 24);
        for (int i = 0; i < 100; i++)
            step(0, 1, 1, (i == pa) || (i == pb) || (i == pc));
        chk("err3", int'(o_err_count), 3);
        chk("bits100", int'(o_bit_count), 100);

        // 5: enable low freezes, then counter saturation
        ll0 = o_locked; dl0 = int'(o_delay);
        el0 = int'(o_err_count); bl0 = int'(o_bit_count);
        for (int i = 0; i < 10; i++) step(0, 0, 1'(i % 2 == 0), 1'($urandom));
        chk("frz_locked", int'(o_locked), int'(ll0));
        chk("frz_delay", int'(o_delay), dl0);
        chk("frz_err", int'(o_err_count), el0);
        chk("frz_bits", int'(o_bit_count), bl0);
        run(300, 1);
        chk("sat_bits", int'(o_bit_count), CMAX);
        chk("sat_err", int'(o_err_count), 3);

        // 6: invert after lock
        bc0 = int'(o_bit_count); ec0 = int'(o_err_count);
        inv = 1;
        run(WIN, 1);
`ifdef BER_LOSS_OF_LOCK_EN
        chk("lol_locked", int'(o_locked), 0);
        chk("lol_delay", int'(o_delay), 0);
        chk("lol_bits", int'(o_bit_count), bc0);
        chk("lol_err", int'(o_err_count), ec0 + 48);
`else
        chk("hold_locked", int'(o_locked), 1);
        chk("hold_err", int'(o_err_count), ec0 + WIN);
        chk("hold_bits", int'(o_bit_count), bc0);
`endif

        // 7: randomized traffic
        inv = 0;
        tx_d = $urandom_range(0, MAXD - 1);
        step(1, 1, 0, 0);
        for (int i = 0; i < 4000; i++)
            step(($urandom % 1500) == 0, ($urandom % 8) != 0,
                 1'($urandom), ($urandom % 200) == 0);

        i_valid = 0; i_enable = 0;
        repeat (3) @(negedge clock);
        if (expq.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending, expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
